// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: UART 8N1 receive path, oversampled directly on in_clk.
//
// The rx line is synchronized, a falling edge in IDLE starts a frame, and every
// bit is sampled at mid-bit. coef (in_clk cycles per bit) is latched when the
// start bit is detected. Received bytes are handed over on a valid/ready
// handshake; stop-bit errors and dropped bytes are flagged with one-cycle pulses.
//
// Ports:
//   in_clk     system clock
//   rst        asynchronous reset, active low
//   coef       in_clk cycles per bit (values below 4 act as 4)
//   rx         asynchronous serial input, idles high
//   data       received byte, stable while valid=1
//   valid      data is available
//   ready      consumer accepts data when valid && ready at a rising edge
//   frame_err  one-cycle pulse: stop bit sampled as 0
//   overrun    one-cycle pulse: frame completed while valid=1, new byte dropped
//   busy       high whenever the receiver is not idle

module uart_rx_sampler #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned SYNC_STAGES = 2  // must be at least 2
) (
    input  logic                 in_clk,
    input  logic                 rst,
    input  logic [13:0]          coef,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned BitW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [13:0]            cnt_q, cnt_d;
    logic [13:0]            c_q, c_d;
    logic [BitW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   pend_q, pend_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;

    logic        rx_s;
    logic [13:0] coef_clamped;
    logic [13:0] half_last;
    logic [13:0] bit_last;

    assign rx_s         = sync_q[SYNC_STAGES-1];
    assign coef_clamped = (coef < 14'd4) ? 14'd4 : coef;
    // Terminal counts: START lasts h cycles, every later bit lasts c cycles.
    assign half_last    = (c_q >> 1) - 14'd1;
    assign bit_last     = c_q - 14'd1;

    always_comb begin
        state_d = state_q;
        sync_d  = {sync_q[SYNC_STAGES-2:0], rx};
        cnt_d   = cnt_q;
        c_d     = c_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pend_d  = 1'b0;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                    cnt_d   = 14'd0;
                    c_d     = coef_clamped;
                    bit_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == half_last) begin
                    cnt_d   = 14'd0;
                    // A start bit that is high again at mid-bit was a glitch.
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 14'd1;
                end
            end
            StData: begin
                if (cnt_q == bit_last) begin
                    cnt_d   = 14'd0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_q == BitW'(DATA_BITS - 1)) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + 14'd1;
                end
            end
            StStop: begin
                if (cnt_q == bit_last) begin
                    cnt_d = 14'd0;
                    bit_d = '0;
                    if (rx_s) begin
                        // Byte is committed to the output on the following edge.
                        pend_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + 14'd1;
                end
            end
            StBreak: begin
                // Wait out a held-low line so it cannot retrigger frames.
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (pend_q) begin
            // Old byte still unaccepted: keep it and drop the new one.
            if (valid_q && !ready) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            sync_q  <= '1;
            cnt_q   <= 14'd0;
            c_q     <= 14'd4;
            bit_q   <= '0;
            shift_q <= '0;
            pend_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != StIdle);

endmodule
